bus_arbiter8: RTL and testbench

//   Round-robin arbiter for the shared 16-bit datapath bus fed by the 8:1 word mux (inputs i0..i7).
//   Up to eight requesters compete for the bus. The arbiter grants one requester at a time and

---
 rtl/bus_arbiter8.sv | 111 +++++++++++
 tb/tb_bus_arbiter8.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin owner select for the shared 16-bit bus behind the 8:1 word mux.
// Optional ARB_LOCK_EN adds a lock input that lets the current owner ride past MAX_HOLD.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   lock    (ARB_LOCK_EN only) extend the current grant past MAX_HOLD
//   req     per-requester bus request, level-held until served
//   gnt     one-hot grant, zero when idle
//   control mux select = owner index; holds last value when idle
//   busy    high while any grant is active
module bus_arbiter8 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] control,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [2:0]       last_owner;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       winner;
  logic             any_req;
  logic             owner_req;
  logic             keep;

`ifdef ARB_LOCK_EN
  assign keep = lock;
`else
  assign keep = 1'b0;
`endif

  assign any_req   = |req;
  assign owner_req = req[control];

  // Scan upward from last_owner+1 with wrap; step 8 lands
  // back on last_owner itself, so a sole requester can win again.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = last_owner;
    found  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_owner + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      control    <= '0;
      busy       <= 1'b0;
      last_owner <= 3'd7;
      hold_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state      <= GRANT;
            gnt        <= 8'(1) << winner;
            control    <= winner;
            busy       <= 1'b1;
            last_owner <= winner;
            hold_cnt   <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (!owner_req && !any_req) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
          end else if (owner_req && hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end else if (owner_req && keep) begin
            hold_cnt <= HOLD_MAX;
          end else begin
            // Owner dropped or used up its slot: hand over without a bubble.
            gnt        <= 8'(1) << winner;
            control    <= winner;
            busy       <= 1'b1;
            last_owner <= winner;
            hold_cnt   <= CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8: table vectors, hand sequences and a random run
// against a behavioural round-robin model.
module tb_bus_arbiter8;

  localparam int MAXH = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       lock_s;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] control;
  logic       busy;

  int total = 0;
  int bad   = 0;

  bus_arbiter8 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef ARB_LOCK_EN
    .lock    (lock_s),
`endif
    .req     (req),
    .gnt     (gnt),
    .control (control),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [2:0] c;
    logic       b;
  } vec_t;

  vec_t vecs[14];

  // Reference model: owner index (-1 = idle), cycles held, rotation pointer.
  int m_owner;
  int m_hold;
  int m_last;
  int m_ctl;

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = 7;
    m_ctl   = 0;
  endtask

  function automatic int pick(input logic [7:0] r, input int last);
    for (int j = 1; j <= 8; j++) begin
      if (r[(last + j) % 8]) return (last + j) % 8;
    end
    return -1;
  endfunction

  task automatic model_grant(input logic [7:0] r);
    m_owner = pick(r, m_last);
    m_last  = m_owner;
    m_ctl   = m_owner;
    m_hold  = 1;
  endtask

  task automatic model_step(input logic [7:0] r, input logic lk);
    if (m_owner < 0) begin
      if (r != 0) model_grant(r);
    end else if (!r[m_owner]) begin
      if (r != 0) model_grant(r);
      else m_owner = -1;
    end else if (m_hold < MAXH) begin
      m_hold = m_hold + 1;
    end else if (LOCK_ON && lk) begin
      m_hold = MAXH;
    end else begin
      model_grant(r);
    end
  endtask

  task automatic check(input string name, input logic [7:0] eg,
                       input logic [2:0] ec, input logic eb);
    total++;
    if (gnt !== eg || control !== ec || busy !== eb) begin
      bad++;
      $display("FAIL %s: got gnt=%h control=%0d busy=%b want gnt=%h control=%0d busy=%b",
               name, gnt, control, busy, eg, ec, eb);
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic lk);
    req    = r;
    lock_s = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    logic [7:0] eg;
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    check(name, eg, 3'(m_ctl), m_owner >= 0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = 8'h00;
    lock_s = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{8'hFF, 8'h01, 3'd0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 3'd0, 1'b1};
    vecs[2]  = '{8'hFF, 8'h01, 3'd0, 1'b1};
    vecs[3]  = '{8'hFF, 8'h01, 3'd0, 1'b1};
    vecs[4]  = '{8'hFF, 8'h02, 3'd1, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 3'd1, 1'b0};
    vecs[6]  = '{8'h44, 8'h04, 3'd2, 1'b1};
    vecs[7]  = '{8'h40, 8'h40, 3'd6, 1'b1};
    vecs[8]  = '{8'h40, 8'h40, 3'd6, 1'b1};
    vecs[9]  = '{8'h41, 8'h40, 3'd6, 1'b1};
    vecs[10] = '{8'h41, 8'h40, 3'd6, 1'b1};
    vecs[11] = '{8'h41, 8'h01, 3'd0, 1'b1};
    vecs[12] = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[13] = '{8'h10, 8'h10, 3'd4, 1'b1};

    lock_s = 1'b0;
    reset  = 1'b1;
    req    = 8'hFF;
    #2;
    check("reset_state", 8'h00, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      begin
        drive(vecs[i].r, 1'b0);
        check($sformatf("vec%0d", i), vecs[i].g, vecs[i].c, vecs[i].b);
      end

    // Sole requester keeps the bus across hold reloads.
    for (int i = 0; i < 10; i++) begin
      drive(8'h10, 1'b0);
      check($sformatf("solo%0d", i), 8'h10, 3'd4, 1'b1);
    end

    // Full rotation with all requesting, MAXH cycles each.
    do_reset();
    for (int i = 0; i < 9 * MAXH; i++) begin
      drive(8'hFF, 1'b0);
      check($sformatf("rot%0d", i), 8'h01 << ((i / MAXH) % 8),
            3'((i / MAXH) % 8), 1'b1);
    end

    // Async reset in the middle of a grant.
    drive(8'h00, 1'b0);
    check("idle_again", 8'h00, 3'd0, 1'b0);
    drive(8'h08, 1'b0);
    check("grant3", 8'h08, 3'd3, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(8'hFF, 1'b0);
    check("post_rst", 8'h01, 3'd0, 1'b1);

`ifdef ARB_LOCK_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(8'h82, 1'b1);
      check($sformatf("lock%0d", i), 8'h02, 3'd1, 1'b1);
    end
    drive(8'h82, 1'b0);
    check("unlock", 8'h80, 3'd7, 1'b1);
`endif

    // Random traffic against the model.
    do_reset();
    begin
      logic [7:0] r;
      logic       lk;
      r  = 8'h00;
      lk = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) r = 8'($urandom);
        if ($urandom_range(0, 7) == 0) r = 8'h00;
        lk = ($urandom_range(0, 3) == 0);
        drive(r, lk);
        model_step(r, lk);
        check_model($sformatf("rand%0d", i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
